// File: rtl/button_event_queue_if.sv
// ---------------------------------------------------------------------------
// button_event_queue_if
//   AHB-Lite slave-port bundle for button_event_queue.
//   master modport : drives HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS;
//                    receives HRDATA, HREADYOUT
//   slave modport  : the mirror image
//   Clock and reset are not carried here; they stay plain module ports.
// ---------------------------------------------------------------------------
interface button_event_queue_if;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic        HREADYOUT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;

  modport master (
    output HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/button_event_queue.sv
// ---------------------------------------------------------------------------
// button_event_queue
//   Captures single-cycle Mode / Trip / Setting / DayNight strobes into a
//   DEPTH-entry FIFO, optionally timestamped with a free-running tick, and
//   exposes them over AHB-Lite with a level interrupt.
//
//   Parameters : DEPTH (power of two, 2..16), TS_WIDTH (<=16), TICK_DIV
//   Ports      : HCLK, HRESETn (async, active-low)
//                bus         AHB-Lite slave (button_event_queue_if.slave)
//                Ev_Mode, Ev_Trip, Ev_Setting, Ev_DayNight  event strobes
//                IRQ         registered level interrupt
//
//   Register map (word offset): 0 DATA (read pops), 1 STATUS, 2 CONTROL,
//   3 TIME.
//
//   Build option: define BUTTON_EVENT_TIMESTAMP_EN to include the prescaler,
//   tick counter, per-entry timestamp storage and the TIME register. Without
//   it DATA[31:16] and TIME read as zero.
// ---------------------------------------------------------------------------
module button_event_queue #(
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16,
  parameter int TICK_DIV = 32
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  button_event_queue_if.slave     bus,
  input  logic                    Ev_Mode,
  input  logic                    Ev_Trip,
  input  logic                    Ev_Setting,
  input  logic                    Ev_DayNight,
  output logic                    IRQ
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_TIME    = 2'd3
  } reg_e;

  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_MODE     = 3'd1,
    EV_TRIP     = 3'd2,
    EV_SETTING  = 3'd3,
    EV_DAYNIGHT = 3'd4
  } ev_code_e;

  // -------------------------------------------------------------------------
  // AHB address phase -> data phase registers
  // -------------------------------------------------------------------------
  logic wr_q;
  logic rd_q;
  reg_e addr_q;
  logic xfer;

  assign xfer = bus.HSEL & bus.HREADY & (bus.HTRANS != 2'b00);

  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= REG_DATA;
    end else begin
      wr_q <= xfer & bus.HWRITE;
      rd_q <= xfer & ~bus.HWRITE;
      if (xfer) addr_q <= reg_e'(bus.HADDR[3:2]);
    end
  end

  // -------------------------------------------------------------------------
  // FIFO state
  // -------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    pending;     // [0] Mode, [1] Trip, [2] Setting, [3] DayNight
  logic          overflow;
  logic          irq_en;
  logic [2:0]    code_mem [DEPTH];

  logic          empty;
  logic          full;
  logic          pop;
  logic          ctrl_wr;
  logic          flush;
  logic          clr_ovf;
  logic [3:0]    pend_all;
  logic [3:0]    sel_bit;
  ev_code_e      sel_code;
  logic          has_push;
  logic          do_write;
  logic          drop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop      = rd_q & (addr_q == REG_DATA) & ~empty;
  assign ctrl_wr  = wr_q & (addr_q == REG_CONTROL);
  assign flush    = ctrl_wr & bus.HWDATA[1];
  assign clr_ovf  = ctrl_wr & bus.HWDATA[2];
  // Strobes of this cycle compete with older pending events immediately.
  assign pend_all = pending | {Ev_DayNight, Ev_Setting, Ev_Trip, Ev_Mode};

  // Fixed priority: Setting > DayNight > Trip > Mode.
  // NOTE: each always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_bit  = 4'b0000;
    sel_code = EV_NONE;
    has_push = 1'b1;
    if      (pend_all[2]) begin sel_bit = 4'b0100; sel_code = EV_SETTING;  end
    else if (pend_all[3]) begin sel_bit = 4'b1000; sel_code = EV_DAYNIGHT; end
    else if (pend_all[1]) begin sel_bit = 4'b0010; sel_code = EV_TRIP;     end
    else if (pend_all[0]) begin sel_bit = 4'b0001; sel_code = EV_MODE;     end
    else                        has_push = 1'b0;
  end

  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign do_write = has_push & (~full | pop) & ~flush;
  assign drop     = has_push & full & ~pop & ~flush;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      IRQ      <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        pending <= '0;
      end else begin
        pending <= pend_all & ~sel_bit;
        if (do_write) wr_ptr <= wr_ptr + AW'(1);
        if (pop)      rd_ptr <= rd_ptr + AW'(1);
        case ({do_write, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end

      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;

      if (ctrl_wr) irq_en <= bus.HWDATA[0];

      IRQ <= irq_en & ~empty;
    end
  end

  // NOTE: the entry storage has no reset; occupancy is tracked by the reset
  // pointers and count, so stale contents are never observable.
  always_ff @(posedge HCLK) begin
    if (do_write) code_mem[wr_ptr] <= sel_code;
  end

  // -------------------------------------------------------------------------
  // Timestamp
  // -------------------------------------------------------------------------
  logic [15:0] ts_field;
  logic [31:0] time_word;

`ifdef BUTTON_EVENT_TIMESTAMP_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]       presc;
  logic [TS_WIDTH-1:0] ts_q;
  logic [TS_WIDTH-1:0] ts_mem [DEPTH];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      presc <= '0;
      ts_q  <= '0;
    end else if (presc == PW'(TICK_DIV - 1)) begin
      presc <= '0;
      ts_q  <= ts_q + TS_WIDTH'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_write) ts_mem[wr_ptr] <= ts_q;
  end

  assign ts_field  = 16'(ts_mem[rd_ptr]);
  assign time_word = 32'(ts_q);
`else
  assign ts_field  = '0;
  assign time_word = '0;
`endif

  // -------------------------------------------------------------------------
  // Read data (combinational in the data phase) and fixed-ready response
  // -------------------------------------------------------------------------
  always_comb begin
    bus.HRDATA = '0;
    if (rd_q) begin
      case (addr_q)
        REG_DATA:    bus.HRDATA = empty ? 32'd0
                                        : {ts_field, 7'd0, 1'b1, 5'd0, code_mem[rd_ptr]};
        REG_STATUS:  bus.HRDATA = {21'd0, overflow, full, empty, 3'd0, 5'(count)};
        REG_CONTROL: bus.HRDATA = {31'd0, irq_en};
        REG_TIME:    bus.HRDATA = time_word;
        default:     bus.HRDATA = '0;
      endcase
    end
  end

  assign bus.HREADYOUT = 1'b1;

  // Bus fields this slave does not decode.
  logic unused_bus_bits;
  assign unused_bus_bits = &{1'b0, bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0],
                             bus.HWDATA[31:3]};

endmodule

// File: tb/tb_button_event_queue.sv
// ---------------------------------------------------------------------------
// tb_button_event_queue
//   Directed bench for button_event_queue. Each AHB read pushes its expected
//   data word into a scoreboard queue; a monitor watching the bus pops and
//   compares whenever a read reaches its data phase.
// ---------------------------------------------------------------------------
module tb_button_event_queue;

  localparam int DEPTH    = 8;
  localparam int TS_WIDTH = 16;
  localparam int TICK_DIV = 32;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  logic HCLK;
  logic HRESETn;
  logic Ev_Mode, Ev_Trip, Ev_Setting, Ev_DayNight;
  logic IRQ;

  button_event_queue_if bus ();

  button_event_queue #(
    .DEPTH   (DEPTH),
    .TS_WIDTH(TS_WIDTH),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .bus        (bus),
    .Ev_Mode    (Ev_Mode),
    .Ev_Trip    (Ev_Trip),
    .Ev_Setting (Ev_Setting),
    .Ev_DayNight(Ev_DayNight),
    .IRQ        (IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Cycle count since reset release; equals the DUT's total prescaler count.
  int tb_cyc;
  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) tb_cyc <= 0;
    else          tb_cyc <= tb_cyc + 1;

  function automatic logic [15:0] ts_at(input int c);
`ifdef BUTTON_EVENT_TIMESTAMP_EN
    return 16'((c / TICK_DIV) % 65536);
`else
    return 16'(c * 0);
`endif
  endfunction

  // ---------------- monitor ----------------
  logic mon_rd;
  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) mon_rd <= 1'b0;
    else          mon_rd <= bus.HSEL && bus.HREADY && (bus.HTRANS != 2'b00) && !bus.HWRITE;

  always @(negedge HCLK) begin
    if (mon_rd) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", bus.HRDATA);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, bus.HRDATA, e.value);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
  endtask

  task automatic idle();
    @(negedge HCLK);
    bus_idle();
  endtask

  task automatic rd(input logic [1:0] a, input string nm, input logic [31:0] exp);
    @(negedge HCLK);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b0;
    bus.HADDR  = {28'd0, a, 2'b00};
    sb.push_back('{nm, exp});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge HCLK);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b1;
    bus.HADDR  = {28'd0, a, 2'b00};
    @(negedge HCLK);
    bus_idle();
    bus.HWDATA = d;
  endtask

  task automatic set_ev(input logic [3:0] m);   // {DayNight, Setting, Trip, Mode}
    {Ev_DayNight, Ev_Setting, Ev_Trip, Ev_Mode} = m;
  endtask

  // One-cycle strobe; returns the timestamp the entry is stamped with.
  task automatic pulse(input logic [3:0] m, output logic [15:0] t);
    @(negedge HCLK);
    set_ev(m);
    t = ts_at(tb_cyc);
    @(negedge HCLK);
    set_ev(4'b0000);
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    HRESETn = 1'b0;
    bus_idle();
    set_ev(4'b0000);
    repeat (2) @(negedge HCLK);
    check("rst_irq",       {31'd0, IRQ}, 32'd0);
    check("rst_hrdata",    bus.HRDATA, 32'd0);
    check("rst_hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
    HRESETn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [15:0] t, t0, t_mode;
  logic [15:0] trip_t [9];

  initial begin
    HRESETn     = 1'b0;
    bus.HADDR   = '0;
    bus.HWDATA  = '0;
    bus.HSIZE   = 3'b010;
    bus.HREADY  = 1'b1;
    bus_idle();
    set_ev(4'b0000);

    // Reset state
    do_reset();
    rd(2'd1, "reset_status", 32'h0000_0100);
    rd(2'd0, "reset_data",   32'h0000_0000);
    rd(2'd2, "reset_ctrl",   32'h0000_0000);
    idle();

    // Single Trip event with IRQ enabled
    wr(2'd2, 32'd1);
    pulse(4'b0010, t);
    check("irq_not_yet", {31'd0, IRQ}, 32'd0);
    @(negedge HCLK);
    check("irq_high", {31'd0, IRQ}, 32'd1);
    rd(2'd0, "trip_data",   {t, 16'h0102});
    rd(2'd1, "trip_status", 32'h0000_0100);
    idle();
    idle();
    check("irq_low", {31'd0, IRQ}, 32'd0);

    // Four simultaneous strobes: drained in priority order, count steps 1..4
    rd(2'd1, "cnt1", 32'h0000_0001);
    set_ev(4'b1111);
    t0 = ts_at(tb_cyc);
    rd(2'd1, "cnt2", 32'h0000_0002);
    set_ev(4'b0000);
    rd(2'd1, "cnt3", 32'h0000_0003);
    rd(2'd1, "cnt4", 32'h0000_0004);
    rd(2'd0, "prio_setting",  {t0,                     16'h0103});
    rd(2'd0, "prio_daynight", {ts_at(int'(tb_cyc) - 3), 16'h0104});
    rd(2'd0, "prio_trip",     {ts_at(int'(tb_cyc) - 3), 16'h0102});
    rd(2'd0, "prio_mode",     {ts_at(int'(tb_cyc) - 3), 16'h0101});
    rd(2'd1, "prio_empty", 32'h0000_0100);
    idle();

    // Overflow: nine Trip strobes into an eight-entry FIFO
    for (int i = 0; i < 9; i++) pulse(4'b0010, trip_t[i]);
    rd(2'd1, "ovf_status", 32'h0000_0608);
    idle();
    wr(2'd2, 32'd4);
    rd(2'd1, "ovf_cleared", 32'h0000_0208);
    idle();

    // Pop and push on the same edge while full
    rd(2'd0, "full_pop0", {trip_t[0], 16'h0102});
    rd(2'd1, "full_pushpop_status", 32'h0000_0208);
    set_ev(4'b0001);
    t_mode = ts_at(tb_cyc);
    for (int i = 1; i < 8; i++) begin
      rd(2'd0, "full_entry", {trip_t[i], 16'h0102});
      if (i == 1) set_ev(4'b0000);
    end
    rd(2'd0, "tail_mode", {t_mode, 16'h0101});
    rd(2'd1, "drained_status", 32'h0000_0100);
    idle();

    // Flush discards queued events
    pulse(4'b0001, t);
    rd(2'd1, "pre_flush", 32'h0000_0001);
    idle();
    wr(2'd2, 32'd2);
    rd(2'd1, "post_flush", 32'h0000_0100);
    rd(2'd2, "ctrl_selfclr", 32'h0000_0000);
    idle();

    // Reset mid-operation, then timestamp after 64 idle cycles
    pulse(4'b0100, t);
    do_reset();
    rd(2'd1, "midrst_status", 32'h0000_0100);   // cycle 1 after release
    rd(2'd0, "midrst_data",   32'h0000_0000);   // cycle 2
    idle();                                    // cycle 3
    repeat (60) @(negedge HCLK);               // cycle 63
`ifdef BUTTON_EVENT_TIMESTAMP_EN
    rd(2'd3, "time_reg", 32'h0000_0002);       // cycle 64
    set_ev(4'b0001);
    rd(2'd0, "ts_data", 32'h0002_0101);
`else
    rd(2'd3, "time_reg", 32'h0000_0000);
    set_ev(4'b0001);
    rd(2'd0, "ts_data", 32'h0000_0101);
`endif
    set_ev(4'b0000);
    idle();
    repeat (3) @(negedge HCLK);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
